column_frame_strobe_gen: RTL and testbench
==========================================

// Module: column_frame_strobe_gen
// PURPOSE
//  Per-column configuration strobe generator; sits directly upstream of the column's terminal tile and drives its FrameStrobe bus.
//  Accepts frame-address requests from the configuration controller over a valid/ready handshake.
//  For each request: matches the column field, then issues a timed one-hot FrameStrobe pulse with setup/hold spacing.
//  Requests for other columns are consumed and dropped; out-of-range frame indices raise a sticky error flag.
// PARAMETERS
//  MaxFramesPerCol   20  width of FrameStrobe (frames per column)
//  FrameSelectWidth  5   width of column-select field
//  FrameIdxWidth     5   width of frame-index field; 2**FrameIdxWidth >= MaxFramesPerCol
//  Col               0   this column's index; compared against addr_col
//  SetupCycles       1   idle cycles between accept and strobe assertion (0 allowed)
//  StrobeCycles      2   cycles FrameStrobe held high (>=1)
//  HoldCycles        1   idle cycles after strobe before next accept (0 allowed)
// PORTS
//  CLK            in   1                   configuration clock
//  resetn         in   1                   asynchronous active-low reset
//  addr_valid     in   1                   request valid
//  addr_ready     out  1                   block can accept a request
//  addr_col       in   FrameSelectWidth    target column
//  addr_frame     in   FrameIdxWidth       target frame within column
//  FrameStrobe    out  MaxFramesPerCol     registered one-hot frame strobe to column tiles
//  busy           out  1                   high in any state other than IDLE
//  err_range      out  1                   sticky: matched request with addr_frame >= MaxFramesPerCol
//  err_clear      in   1                   synchronous clear of err_range
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, FrameStrobe=0, err_range=0, counters=0; addr_ready=1 on first cycle after release.
//  Strobe drops to 0 immediately on resetn assertion, including mid-pulse; no partial pulse resumes afterwards.
//  Accept = addr_valid & addr_ready; addr_ready = (state==IDLE); inputs captured only on accept.
//  States: IDLE, SETUP, STROBE, HOLD. Counter width clog2(max(Setup,Strobe,Hold)+1).
//   IDLE: on accept with addr_col!=Col -> stay IDLE (dropped, one-cycle consume).
//         on accept, col match, addr_frame>=MaxFramesPerCol -> stay IDLE, err_range<=1, no strobe.
//         on accept, col match, valid frame -> SETUP (or STROBE if SetupCycles==0).
//   SETUP: SetupCycles cycles, FrameStrobe=0 -> STROBE.
//   STROBE: FrameStrobe = 1<<frame_q for exactly StrobeCycles cycles -> HOLD (or IDLE if HoldCycles==0).
//   HOLD: HoldCycles cycles, FrameStrobe=0 -> IDLE.
//  Latency: accept at edge N -> FrameStrobe high on edges N+1+SetupCycles .. N+SetupCycles+StrobeCycles.
//  Throughput: one matched request per 1+Setup+Strobe+Hold cycles; addr_ready low throughout.
//  FrameStrobe is never multi-hot; all-zero outside STROBE.
//  err_range: set has priority over err_clear in the same cycle; otherwise err_clear clears it.
//  addr_valid held while addr_ready=0: no effect; request accepted on first IDLE cycle.
//  addr_col/addr_frame changes after accept: ignored (captured registers used).
// STRUCTURE
//  Shared package cfg_frame_pkg: state enum (IDLE/SETUP/STROBE/HOLD), default FrameSelectWidth/FrameIdxWidth/MaxFramesPerCol constants.
//  Single module; one natural sub-module: frame_onehot_dec (FrameIdxWidth -> MaxFramesPerCol decoder, range flag).
//  All outputs registered; no combinational path addr_* -> FrameStrobe.
// TESTING
//  Col=3, Setup=1,Strobe=2,Hold=1: accept col=3 frame=7 at edge 10 -> FrameStrobe=20'h00080 on edges 12-13, addr_ready back edge 15.
//  Accept col=5 frame=2 (Col=3) -> FrameStrobe stays 0, addr_ready stays 1, no busy.
//  Accept col=3 frame=25 -> no strobe, err_range=1 next edge; err_clear pulse -> 0; set+clear same cycle -> stays 1.
//  Back-to-back valid frames 0 then 19 -> strobes 20'h00001 then 20'h80000, gap exactly Hold+1+Setup cycles.
//  Assert resetn=0 during STROBE -> FrameStrobe=0 same cycle (async), after release IDLE, no resumed pulse.
//  Setup=0,Hold=0 build: accept frame=0 -> strobe on next edge; continuous valid gives 1+Strobe cycle period.

Source files
------------

// File: rtl/cfg_frame_pkg.sv
// ============================================================================
// Module      : cfg_frame_pkg
// Description : Shared types and default geometry for column frame strobing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfg_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } strobe_state_t;

  localparam int c_default_frame_select_width = 5;
  localparam int c_default_frame_idx_width    = 5;
  localparam int c_default_max_frames_per_col = 20;

endpackage : cfg_frame_pkg

`default_nettype wire

// File: rtl/frame_onehot_dec.sv
// ============================================================================
// Module      : frame_onehot_dec
// Description : Frame index to one-hot strobe decoder with range flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_onehot_dec
  import cfg_frame_pkg::*;
#(
  parameter int FRAME_IDX_WIDTH    = c_default_frame_idx_width,
  parameter int MAX_FRAMES_PER_COL = c_default_max_frames_per_col
) (
  input  logic [FRAME_IDX_WIDTH-1:0]    i_frame,
  output logic [MAX_FRAMES_PER_COL-1:0] o_onehot,
  output logic                          o_in_range
);

  localparam logic [FRAME_IDX_WIDTH:0] c_frame_limit = (FRAME_IDX_WIDTH+1)'(MAX_FRAMES_PER_COL);

  // Out-of-range indices decode to all-zero, so the strobe can never be multi-hot.
  for (genvar i = 0; i < MAX_FRAMES_PER_COL; i++) begin : g_bit
    assign o_onehot[i] = (i_frame == FRAME_IDX_WIDTH'(i));
  end

  assign o_in_range = ({1'b0, i_frame} < c_frame_limit);

endmodule : frame_onehot_dec

`default_nettype wire

// File: rtl/column_frame_strobe_gen.sv
// ============================================================================
// Module      : column_frame_strobe_gen
// Description : Per-column FrameStrobe generator with setup/strobe/hold timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module column_frame_strobe_gen
  import cfg_frame_pkg::*;
#(
  parameter int MAX_FRAMES_PER_COL = c_default_max_frames_per_col,
  parameter int FRAME_SELECT_WIDTH = c_default_frame_select_width,
  parameter int FRAME_IDX_WIDTH    = c_default_frame_idx_width,
  parameter int COL                = 0,
  parameter int SETUP_CYCLES       = 1,
  parameter int STROBE_CYCLES      = 2,
  parameter int HOLD_CYCLES        = 1
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic                          addr_valid,
  output logic                          addr_ready,
  input  logic [FRAME_SELECT_WIDTH-1:0] addr_col,
  input  logic [FRAME_IDX_WIDTH-1:0]    addr_frame,
  output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                          busy,
  output logic                          err_range,
  input  logic                          err_clear
);

  localparam int c_max_ss  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int c_max_cyc = (c_max_ss > HOLD_CYCLES) ? c_max_ss : HOLD_CYCLES;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

  localparam logic [c_cnt_w-1:0] c_setup_ld  = c_cnt_w'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_strobe_ld = c_cnt_w'(STROBE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_hold_ld   = c_cnt_w'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  strobe_state_t                 r_state;
  logic [c_cnt_w-1:0]            r_cnt;
  logic [MAX_FRAMES_PER_COL-1:0] r_onehot;

  logic [MAX_FRAMES_PER_COL-1:0] w_onehot;
  logic                          w_in_range;
  logic                          w_accept;
  logic                          w_col_hit;

  frame_onehot_dec #(
    .FRAME_IDX_WIDTH    (FRAME_IDX_WIDTH),
    .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL)
  ) u_dec (
    .i_frame    (addr_frame),
    .o_onehot   (w_onehot),
    .o_in_range (w_in_range)
  );

  assign w_accept  = addr_valid & addr_ready;
  assign w_col_hit = (addr_col == FRAME_SELECT_WIDTH'(COL));

  // Outputs are loaded alongside the state transition, so each one reflects
  // the state being entered and no addr_* path reaches FrameStrobe unregistered.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_onehot    <= '0;
      FrameStrobe <= '0;
      addr_ready  <= 1'b1;
      busy        <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (err_clear) begin
        err_range <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_col_hit) begin
            if (!w_in_range) begin
              err_range <= 1'b1;
            end else begin
              r_onehot   <= w_onehot;
              addr_ready <= 1'b0;
              busy       <= 1'b1;
              if (SETUP_CYCLES > 0) begin
                r_state <= ST_SETUP;
                r_cnt   <= c_setup_ld;
              end else begin
                r_state     <= ST_STROBE;
                r_cnt       <= c_strobe_ld;
                FrameStrobe <= w_onehot;
              end
            end
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_state     <= ST_STROBE;
            r_cnt       <= c_strobe_ld;
            FrameStrobe <= r_onehot;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (r_cnt == '0) begin
            FrameStrobe <= '0;
            if (HOLD_CYCLES > 0) begin
              r_state <= ST_HOLD;
              r_cnt   <= c_hold_ld;
            end else begin
              r_state    <= ST_IDLE;
              addr_ready <= 1'b1;
              busy       <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state    <= ST_IDLE;
            addr_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          FrameStrobe <= '0;
          addr_ready  <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule : column_frame_strobe_gen

`default_nettype wire

// File: tb/tb_column_frame_strobe_gen.sv
// ============================================================================
// Module      : tb_column_frame_strobe_gen
// Description : Directed self-checking bench for column_frame_strobe_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_column_frame_strobe_gen;

  logic        CLK;
  logic        resetn;

  logic        a_valid, a_ready, a_busy, a_err, a_clear;
  logic [4:0]  a_col, a_frame;
  logic [19:0] a_fs;

  logic        b_valid, b_ready, b_busy, b_err, b_clear;
  logic [4:0]  b_col, b_frame;
  logic [19:0] b_fs;

  int n_tests = 0;
  int n_fail  = 0;

  column_frame_strobe_gen #(
    .MAX_FRAMES_PER_COL (20), .FRAME_SELECT_WIDTH (5), .FRAME_IDX_WIDTH (5),
    .COL (3), .SETUP_CYCLES (1), .STROBE_CYCLES (2), .HOLD_CYCLES (1)
  ) u_dut_a (
    .CLK (CLK), .resetn (resetn), .addr_valid (a_valid), .addr_ready (a_ready),
    .addr_col (a_col), .addr_frame (a_frame), .FrameStrobe (a_fs),
    .busy (a_busy), .err_range (a_err), .err_clear (a_clear)
  );

  column_frame_strobe_gen #(
    .MAX_FRAMES_PER_COL (20), .FRAME_SELECT_WIDTH (5), .FRAME_IDX_WIDTH (5),
    .COL (3), .SETUP_CYCLES (0), .STROBE_CYCLES (2), .HOLD_CYCLES (0)
  ) u_dut_b (
    .CLK (CLK), .resetn (resetn), .addr_valid (b_valid), .addr_ready (b_ready),
    .addr_col (b_col), .addr_frame (b_frame), .FrameStrobe (b_fs),
    .busy (b_busy), .err_range (b_err), .err_clear (b_clear)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle to the following falling edge for sampling.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  logic [19:0] exp_fs_d [9];
  logic [19:0] exp_fs_f [9];
  logic        exp_rdy_f [9];

  initial begin
    resetn  = 1'b0;
    a_valid = 1'b0; a_col = '0; a_frame = '0; a_clear = 1'b0;
    b_valid = 1'b0; b_col = '0; b_frame = '0; b_clear = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_fs",    32'(a_fs),    32'h0);
    chk("rst_ready", 32'(a_ready), 32'h1);
    chk("rst_busy",  32'(a_busy),  32'h0);
    chk("rst_err",   32'(a_err),   32'h0);
    resetn = 1'b1;
    step();
    chk("post_rst_ready", 32'(a_ready), 32'h1);

    // Matched request col=3 frame=7: setup, two strobe cycles, hold, idle
    a_valid = 1'b1; a_col = 5'd3; a_frame = 5'd7;
    step();
    a_valid = 1'b0; a_col = 5'd9; a_frame = 5'd1;
    chk("a_setup_fs",    32'(a_fs),    32'h0);
    chk("a_setup_ready", 32'(a_ready), 32'h0);
    chk("a_setup_busy",  32'(a_busy),  32'h1);
    step();
    chk("a_strobe1", 32'(a_fs), 32'h00080);
    step();
    chk("a_strobe2", 32'(a_fs), 32'h00080);
    step();
    chk("a_hold_fs",    32'(a_fs),    32'h0);
    chk("a_hold_ready", 32'(a_ready), 32'h0);
    step();
    chk("a_idle_ready", 32'(a_ready), 32'h1);
    chk("a_idle_busy",  32'(a_busy),  32'h0);

    // Other column: consumed and dropped
    a_valid = 1'b1; a_col = 5'd5; a_frame = 5'd2;
    step();
    a_valid = 1'b0;
    chk("drop_ready", 32'(a_ready), 32'h1);
    chk("drop_busy",  32'(a_busy),  32'h0);
    chk("drop_fs",    32'(a_fs),    32'h0);
    step();
    chk("drop_fs2", 32'(a_fs), 32'h0);

    // Out-of-range frame, clear, and set-wins-over-clear
    a_valid = 1'b1; a_col = 5'd3; a_frame = 5'd25;
    step();
    a_valid = 1'b0;
    chk("err_set",   32'(a_err),   32'h1);
    chk("err_fs",    32'(a_fs),    32'h0);
    chk("err_ready", 32'(a_ready), 32'h1);
    step();
    chk("err_fs2", 32'(a_fs), 32'h0);
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    chk("err_cleared", 32'(a_err), 32'h0);
    a_valid = 1'b1; a_frame = 5'd20; a_clear = 1'b1;
    step();
    a_valid = 1'b0; a_clear = 1'b0;
    chk("err_set_over_clear", 32'(a_err), 32'h1);
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    chk("err_cleared2", 32'(a_err), 32'h0);

    // Back-to-back frames 0 then 19 with valid held while busy
    exp_fs_d = '{20'h00001, 20'h00001, 20'h0, 20'h0, 20'h0,
                 20'h80000, 20'h80000, 20'h0, 20'h0};
    a_valid = 1'b1; a_col = 5'd3; a_frame = 5'd0;
    step();
    chk("b2b_setup0", 32'(a_fs), 32'h0);
    a_frame = 5'd19;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("b2b_fs_%0d", i), 32'(a_fs), 32'(exp_fs_d[i]));
      if (i == 4) a_valid = 1'b0;
    end
    chk("b2b_err", 32'(a_err), 32'h0);

    // Asynchronous reset in the middle of a strobe pulse
    a_valid = 1'b1; a_col = 5'd3; a_frame = 5'd4;
    step();
    a_valid = 1'b0;
    step();
    chk("rst_mid_pre", 32'(a_fs), 32'h00010);
    resetn = 1'b0;
    #1;
    chk("rst_mid_fs",    32'(a_fs),    32'h0);
    chk("rst_mid_ready", 32'(a_ready), 32'h1);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst_after_fs_%0d", i), 32'(a_fs), 32'h0);
    end
    chk("rst_after_ready", 32'(a_ready), 32'h1);
    chk("rst_after_busy",  32'(a_busy),  32'h0);

    // Zero setup/hold build with continuous valid
    exp_fs_f  = '{20'h1, 20'h1, 20'h0, 20'h1, 20'h1, 20'h0, 20'h1, 20'h1, 20'h0};
    exp_rdy_f = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    b_valid = 1'b1; b_col = 5'd3; b_frame = 5'd0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("fast_fs_%0d", i),    32'(b_fs),    32'(exp_fs_f[i]));
      chk($sformatf("fast_ready_%0d", i), 32'(b_ready), 32'(exp_rdy_f[i]));
      if (i == 7) b_valid = 1'b0;
    end
    chk("fast_busy", 32'(b_busy), 32'h0);
    chk("fast_err",  32'(b_err),  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_column_frame_strobe_gen

`default_nettype wire
